stm_gain_loader: RTL and testbench

Write-side loader for the gain-STM pattern memory: accepts a streamed sequence of per-transducer (intensity, phase) pairs and writes them into the selected STM segment as consecutive patterns. It sits between the host/controller data path and the STM BRAM write port. Its address layout is exactly the one the `stm` gain read path consumes, so patterns it loads are read back unchanged through `stm`'s INTENSITY/PHASE outputs.

---
 rtl/stm_gain_loader.sv | 188 ++++++++++++++++++
 tb/tb_stm_gain_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stm_gain_loader.sv
// -----------------------------------------------------------------------------
// stm_gain_loader
//
// Write-side loader for the gain-STM pattern memory. A START pulse in IDLE
// latches the target segment and the pattern count. The block then accepts a
// stream of (intensity, phase) pairs, one per transducer, and writes each one
// to the STM BRAM at {segment, pattern[12:0], transducer[7:0]}. This is the
// layout the stm gain read path uses, so loaded patterns read back unchanged.
//
// Ports
//   CLK, RST_N     clock, asynchronous active-low reset
//   START          begin a load (sampled only in IDLE)
//   SEGMENT        target segment, latched on an accepted START
//   CYCLE          number of patterns; 0 is ignored, values above 8192 clamp
//   DIN_VALID      input pair valid
//   DIN_READY      loader accepts the pair this cycle (combinational on MEM_BUSY)
//   INTENSITY_IN   intensity of the current transducer
//   PHASE_IN       phase of the current transducer
//   MEM_WE         BRAM write request
//   MEM_ADDR       BRAM write address
//   MEM_DATA       BRAM write data {intensity, phase}
//   MEM_BUSY       BRAM stall; a write completes when MEM_WE=1 and MEM_BUSY=0
//   BUSY           high while a load is in progress
//   DONE           one-cycle pulse after the final write completes
// -----------------------------------------------------------------------------
module stm_gain_loader #(
    parameter int DEPTH       = 249,
    parameter int CYCLE_WIDTH = 14
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
    input  logic                   SEGMENT,
    input  logic [CYCLE_WIDTH-1:0] CYCLE,
    input  logic                   DIN_VALID,
    output logic                   DIN_READY,
    input  logic [7:0]             INTENSITY_IN,
    input  logic [7:0]             PHASE_IN,
    output logic                   MEM_WE,
    output logic [21:0]            MEM_ADDR,
    output logic [15:0]            MEM_DATA,
    input  logic                   MEM_BUSY,
    output logic                   BUSY,
    output logic                   DONE
);

    // The clamp compare needs at least 14 bits so that 8192 is representable.
    localparam int             EXT_W     = (CYCLE_WIDTH > 14) ? CYCLE_WIDTH : 14;
    localparam logic [EXT_W-1:0] CYCLE_MAX = EXT_W'(32'd8192);
    localparam logic [7:0]     TR_LAST   = 8'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_r,  state_n_s;
    logic        seg_r,    seg_n_s;
    logic [13:0] cyc_r,    cyc_n_s;
    logic [12:0] pat_r,    pat_n_s;
    logic [7:0]  tr_r,     tr_n_s;
    logic        we_r,     we_n_s;
    logic [21:0] addr_r,   addr_n_s;
    logic [15:0] data_r,   data_n_s;
    logic        busy_r,   busy_n_s;
    logic        done_r,   done_n_s;

    logic [EXT_W-1:0] cycle_ext_s;
    logic [13:0]      cycle_clamp_s;
    logic             cycle_zero_s;
    logic             stall_s;
    logic             ready_s;
    logic             xfer_s;
    logic             last_s;

    assign cycle_ext_s   = EXT_W'(CYCLE);
    assign cycle_zero_s  = (cycle_ext_s == {EXT_W{1'b0}});
    assign cycle_clamp_s = (cycle_ext_s > CYCLE_MAX) ? 14'd8192 : cycle_ext_s[13:0];

    // A pending write held off by the BRAM blocks new input so the held
    // address/data cannot be overwritten.
    assign stall_s = we_r && MEM_BUSY;
    assign ready_s = (state_r == ST_LOAD) && !stall_s;
    assign xfer_s  = DIN_VALID && ready_s;
    assign last_s  = ({1'b0, pat_r} == (cyc_r - 14'd1)) && (tr_r == TR_LAST);

    // Next-state, counter and write-port logic.
    always_comb begin
        state_n_s = state_r;
        seg_n_s   = seg_r;
        cyc_n_s   = cyc_r;
        pat_n_s   = pat_r;
        tr_n_s    = tr_r;
        addr_n_s  = addr_r;
        data_n_s  = data_r;
        done_n_s  = 1'b0;

        // A completed write drops the request; a transfer below re-arms it.
        if (we_r && !MEM_BUSY) begin
            we_n_s = 1'b0;
        end else begin
            we_n_s = we_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (START && !cycle_zero_s) begin
                    state_n_s = ST_LOAD;
                    seg_n_s   = SEGMENT;
                    cyc_n_s   = cycle_clamp_s;
                    pat_n_s   = 13'd0;
                    tr_n_s    = 8'd0;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    we_n_s   = 1'b1;
                    addr_n_s = {seg_r, pat_r, tr_r};
                    data_n_s = {INTENSITY_IN, PHASE_IN};
                    if (tr_r == TR_LAST) begin
                        tr_n_s  = 8'd0;
                        pat_n_s = pat_r + 13'd1;
                    end else begin
                        tr_n_s  = tr_r + 8'd1;
                    end
                    if (last_s) begin
                        state_n_s = ST_DRAIN;
                    end else begin
                        state_n_s = ST_LOAD;
                    end
                end else begin
                    state_n_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!stall_s) begin
                    state_n_s = ST_IDLE;
                    done_n_s  = 1'b1;
                end else begin
                    state_n_s = ST_DRAIN;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase

        busy_n_s = (state_n_s != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            seg_r   <= 1'b0;
            cyc_r   <= 14'd0;
            pat_r   <= 13'd0;
            tr_r    <= 8'd0;
            we_r    <= 1'b0;
            addr_r  <= 22'd0;
            data_r  <= 16'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            seg_r   <= seg_n_s;
            cyc_r   <= cyc_n_s;
            pat_r   <= pat_n_s;
            tr_r    <= tr_n_s;
            we_r    <= we_n_s;
            addr_r  <= addr_n_s;
            data_r  <= data_n_s;
            busy_r  <= busy_n_s;
            done_r  <= done_n_s;
        end
    end

    assign DIN_READY = ready_s;
    assign MEM_WE    = we_r;
    assign MEM_ADDR  = addr_r;
    assign MEM_DATA  = data_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;

endmodule

// File: tb/tb_stm_gain_loader.sv
// -----------------------------------------------------------------------------
// tb_stm_gain_loader
//
// Directed bench for stm_gain_loader. A table of load scenarios (segment,
// pattern count, input/stall behaviour, expected write count and one
// hand-computed probe address) is applied in a loop; each write is compared
// against the pair that was sent and the address {seg, k/DEPTH, k%DEPTH}.
// Hand-written sequences cover CYCLE=0 and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_stm_gain_loader;

    localparam int DEPTH = 249;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic        SEGMENT;
    logic [13:0] CYCLE;
    logic        DIN_VALID;
    logic        DIN_READY;
    logic [7:0]  INTENSITY_IN;
    logic [7:0]  PHASE_IN;
    logic        MEM_WE;
    logic [21:0] MEM_ADDR;
    logic [15:0] MEM_DATA;
    logic        MEM_BUSY;
    logic        BUSY;
    logic        DONE;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] pairs [4096];

    typedef struct {
        logic        seg;
        logic [13:0] cyc;
        logic        rand_valid;
        logic        stall;
        logic        start_mid;
        int          exp_writes;
        int          probe_k;
        logic [21:0] probe_addr;
    } vec_t;

    vec_t vecs [4];
    vec_t v_abort;
    vec_t v_fresh;

    stm_gain_loader #(.DEPTH(DEPTH), .CYCLE_WIDTH(14)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .START        (START),
        .SEGMENT      (SEGMENT),
        .CYCLE        (CYCLE),
        .DIN_VALID    (DIN_VALID),
        .DIN_READY    (DIN_READY),
        .INTENSITY_IN (INTENSITY_IN),
        .PHASE_IN     (PHASE_IN),
        .MEM_WE       (MEM_WE),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_DATA     (MEM_DATA),
        .MEM_BUSY     (MEM_BUSY),
        .BUSY         (BUSY),
        .DONE         (DONE)
    );

    // 100 MHz clock.
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(DIN_READY), 32'd0);
        chk({tag, "_we"},    32'(MEM_WE),    32'd0);
        chk({tag, "_addr"},  32'(MEM_ADDR),  32'd0);
        chk({tag, "_data"},  32'(MEM_DATA),  32'd0);
        chk({tag, "_busy"},  32'(BUSY),      32'd0);
        chk({tag, "_done"},  32'(DONE),      32'd0);
    endtask

    // Runs one load. Entered at posedge+1 or at a negedge (the DONE cycle of
    // a previous load, so back-to-back START acceptance is exercised).
    // With abort_at >= 0 it returns at posedge+1 once that many pairs went in.
    task automatic run_load(input vec_t v, input int abort_at);
        int          k = 0;
        int          w = 0;
        int          stall_left = 0;
        bit          done_due = 1'b0;
        bit          prev_xfer = 1'b0;
        bit          stall_now = 1'b0;
        bit          stalled_once = 1'b0;
        bit          finished = 1'b0;
        logic [21:0] exp_addr;
        logic [21:0] held_addr = 22'd0;
        logic [15:0] held_data = 16'd0;

        for (int i = 0; i < v.exp_writes; i++) pairs[i] = 16'($urandom);

        START = 1'b1; SEGMENT = v.seg; CYCLE = v.cyc;
        DIN_VALID = 1'b0; MEM_BUSY = 1'b0;
        @(posedge CLK); #1;
        // Changing the latched inputs afterwards must have no effect.
        START = 1'b0; SEGMENT = ~v.seg; CYCLE = 14'd1;
        chk("start_busy",  32'(BUSY),      32'd1);
        chk("start_ready", 32'(DIN_READY), 32'd1);

        for (int c = 0; c < v.exp_writes * 4 + 50 && !finished; c++) begin
            START = v.start_mid && (c == 10);
            stall_now = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                stall_now = 1'b1;
            end else if (v.stall && !stalled_once && k >= 50 && MEM_WE) begin
                stalled_once = 1'b1;
                stall_left   = 4;
                stall_now    = 1'b1;
                held_addr    = MEM_ADDR;
                held_data    = MEM_DATA;
            end
            MEM_BUSY  = stall_now;
            DIN_VALID = (k < v.exp_writes) && (v.rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
            INTENSITY_IN = (k < v.exp_writes) ? pairs[k][15:8] : 8'd0;
            PHASE_IN     = (k < v.exp_writes) ? pairs[k][7:0]  : 8'd0;

            @(negedge CLK);
            if (done_due) begin
                chk("done_pulse", 32'(DONE), 32'd1);
                chk("done_busy",  32'(BUSY), 32'd0);
                finished = 1'b1;
            end else begin
                chk("done_low", 32'(DONE), 32'd0);
                if (prev_xfer) chk("we_after_xfer", 32'(MEM_WE), 32'd1);
                if (stall_now) begin
                    chk("stall_ready", 32'(DIN_READY), 32'd0);
                    chk("stall_addr",  32'(MEM_ADDR),  32'(held_addr));
                    chk("stall_data",  32'(MEM_DATA),  32'(held_data));
                end
                if (MEM_WE && !MEM_BUSY) begin
                    if (w < v.exp_writes) begin
                        exp_addr = {v.seg, 13'(w / DEPTH), 8'(w % DEPTH)};
                        chk($sformatf("wr_addr[%0d]", w), 32'(MEM_ADDR), 32'(exp_addr));
                        chk($sformatf("wr_data[%0d]", w), 32'(MEM_DATA), 32'(pairs[w]));
                        if (w == v.probe_k) chk("probe_addr", 32'(MEM_ADDR), 32'(v.probe_addr));
                    end else begin
                        chk("extra_write", 32'(w + 1), 32'(v.exp_writes));
                    end
                    w++;
                    if (w == v.exp_writes) done_due = 1'b1;
                end
                prev_xfer = DIN_VALID && DIN_READY;
                if (prev_xfer) k++;
                if (abort_at >= 0 && k == abort_at) begin
                    @(posedge CLK); #1;
                    return;
                end
                @(posedge CLK); #1;
            end
        end
        if (!finished) chk("done_timeout", 32'd0, 32'd1);
        chk("write_count", 32'(w), 32'(v.exp_writes));
        chk("xfer_count",  32'(k), 32'(v.exp_writes));
        DIN_VALID = 1'b0;
    endtask

    initial begin
        vecs[0] = '{seg:1'b0, cyc:14'd16, rand_valid:1'b0, stall:1'b0, start_mid:1'b0,
                    exp_writes:3984, probe_k:1255, probe_addr:22'h00050A};
        vecs[1] = '{seg:1'b1, cyc:14'd4,  rand_valid:1'b1, stall:1'b0, start_mid:1'b1,
                    exp_writes:996,  probe_k:0,    probe_addr:22'h200000};
        vecs[2] = '{seg:1'b0, cyc:14'd2,  rand_valid:1'b0, stall:1'b1, start_mid:1'b0,
                    exp_writes:498,  probe_k:300,  probe_addr:22'h000133};
        vecs[3] = '{seg:1'b1, cyc:14'd1,  rand_valid:1'b1, stall:1'b1, start_mid:1'b1,
                    exp_writes:249,  probe_k:248,  probe_addr:22'h2000F8};
        v_abort = '{seg:1'b1, cyc:14'd2,  rand_valid:1'b0, stall:1'b0, start_mid:1'b0,
                    exp_writes:498,  probe_k:5,    probe_addr:22'h200005};
        v_fresh = '{seg:1'b0, cyc:14'd1,  rand_valid:1'b0, stall:1'b0, start_mid:1'b0,
                    exp_writes:249,  probe_k:0,    probe_addr:22'h000000};

        RST_N = 1'b0; START = 1'b0; SEGMENT = 1'b0; CYCLE = 14'd0;
        DIN_VALID = 1'b0; INTENSITY_IN = 8'd0; PHASE_IN = 8'd0; MEM_BUSY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk_all_zero("idle");

        for (int i = 0; i < 4; i++) run_load(vecs[i], -1);

        // CYCLE=0 is ignored, here issued in the DONE cycle of the last load.
        START = 1'b1; SEGMENT = 1'b0; CYCLE = 14'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            chk("cyc0_busy",  32'(BUSY),      32'd0);
            chk("cyc0_we",    32'(MEM_WE),    32'd0);
            chk("cyc0_ready", 32'(DIN_READY), 32'd0);
        end

        // Reset after 100 transfers, then a fresh load from address 0.
        run_load(v_abort, 100);
        RST_N = 1'b0; DIN_VALID = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge CLK);
        chk_all_zero("midrst_next");
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("post_rst_done", 32'(DONE), 32'd0);
            chk("post_rst_busy", 32'(BUSY), 32'd0);
        end
        run_load(v_fresh, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
